spi_flash_reader: RTL and testbench
===================================

// Module: spi_flash_reader
// PURPOSE
//   SPI-mode-0 read engine that drives the on-board configuration flash.
//   It issues READ (0x03) plus a 24-bit address, then streams LEN data bytes back to the core as valid-pulsed bytes.
//   It sits between the core logic and the FLASH_CS / FLASH_MOSI / FLASH_MISO pins; spi_sclk feeds the user-CCLK primitive input.
// PARAMETERS
//   CLK_DIV  1   clk cycles per SCLK half-period (tick interval); legal range >= 1
//   LEN_W    8   width of the byte-count input
// PORTS
//   clk         in   1      system clock; the only clock in the block
//   rst_n       in   1      asynchronous, active-low reset
//   start       in   1      request a read; sampled only in IDLE
//   addr        in   24     flash byte address; captured on the accepted start
//   len         in   LEN_W  number of bytes to read; captured on the accepted start
//   busy        out  1      high from the cycle after start is accepted until done
//   done        out  1      1-cycle pulse at the end of the transaction
//   data_out    out  8      last received byte, MSB first on the wire
//   data_valid  out  1      1-cycle pulse when data_out is updated
//   spi_sclk    out  1      SPI clock; idles low
//   spi_cs_n    out  1      flash chip select; idles high
//   spi_mosi    out  1      command/address bits, MSB first
//   spi_miso    in   1      flash data in
// BEHAVIOUR
//   Reset (asynchronous): all outputs return to their idle values immediately, including mid-transaction.
//     - Idle values: busy=0, done=0, data_valid=0, data_out=8'h00, spi_sclk=0, spi_cs_n=1, spi_mosi=0.
//     - FSM goes to IDLE; the tick counter and shift registers clear.
//   FSM states: IDLE -> CMD (8 bits) -> ADDR (24 bits) -> DATA (8*len bits) -> FINISH -> IDLE.
//   Tick timing: a tick occurs every CLK_DIV cycles; the tick counter restarts when start is accepted.
//   Start acceptance: in IDLE, start=1 at a clk edge is accepted.
//     - addr and len are latched.
//     - On the next cycle: busy=1, spi_cs_n=0, spi_sclk=0, spi_mosi = bit 7 of 0x03.
//   Each bit spans two ticks:
//     - Tick A: sclk rises; spi_miso is sampled into the receive shift register.
//     - Tick B: sclk falls; spi_mosi moves to the next bit.
//     - spi_mosi is held at 0 during DATA.
//   Byte delivery: on the rising-edge tick of the 8th bit of each data byte, the next clk cycle has:
//     - data_out = the assembled byte;
//     - data_valid = 1 for exactly one cycle.
//     data_out holds until the next byte arrives.
//   End of DATA: the falling-edge tick of the last data bit enters FINISH with spi_cs_n=1 and sclk=0.
//     - FINISH lasts one tick, which guarantees the minimum deselect time.
//     - On exiting FINISH: done=1 for one cycle, busy=0 in the same cycle, FSM returns to IDLE.
//   Latency: let B = 32 + 8*len and N = CLK_DIV, with start accepted at cycle 0.
//     - spi_cs_n is low from cycle 1 through cycle 2*N*B.
//     - done is asserted at cycle 1 + 2*N*B + N.
//   len = 0: the start is accepted but no SPI activity occurs; spi_cs_n stays high.
//     - busy stays 0; done pulses on the next cycle.
//   start while busy: ignored; latched addr and len do not change.
//   start in the same cycle that done pulses: accepted, because the FSM is already in IDLE that cycle.
//   Counters: the bit counter covers up to 32 + 8*(2^LEN_W - 1) bits with no wrap; the address is not incremented by the block.
// TESTING
//   1. Reset with the SPI pins toggling -> idle values as listed, no data_valid, no done.
//   2. CLK_DIV=1, addr=24'h123456, len=1, model returns 8'hA5:
//      -> MOSI stream 03 12 34 56; one data_valid with data_out=8'hA5; done at cycle 82.
//   3. len=4, model returns 11 22 33 44 -> four data_valid pulses carrying those bytes in order, 16 clk apart; one done pulse.
//   4. len=0 -> spi_cs_n never low, busy stays 0, done at cycle 1.
//   5. Second start pulsed during ADDR -> ignored; a start in the done cycle -> new transaction begins.
//   6. Assert rst_n=0 mid-ADDR -> spi_cs_n=1 and spi_sclk=0 in the same cycle (async).
//      After release, a CLK_DIV=3, len=1 read completes with done at cycle 1+6*40+3=244.

Source files
------------

// File: rtl/spi_flash_reader.sv
// SPI mode-0 read engine for the configuration flash.
// It sends READ (0x03) and a 24-bit address, then returns len bytes as valid-pulsed bytes.
module spi_flash_reader #(
    parameter int CLK_DIV = 1,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       data_out,
    output logic             data_valid,
    output logic             spi_sclk,
    output logic             spi_cs_n,
    output logic             spi_mosi,
    input  logic             spi_miso
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(CLK_DIV - 1);
    // Bit counter must reach 31 + 8*(2^LEN_W - 1) without wrapping.
    localparam int BW = LEN_W + 4;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, FINISH} state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [CW-1:0]   r_tickCnt;
    logic            r_sclk;
    logic [BW-1:0]   r_bitCnt;
    logic [BW-1:0]   r_lastBit;
    logic [31:0]     r_txSr;
    logic [7:0]      r_rxSr;
    logic [7:0]      r_dataOut;
    logic            r_valid;
    logic            r_done;
    logic            w_tick;
    logic            w_shifting;
    logic            w_riseTick;
    logic            w_fallTick;

    assign w_tick     = (r_state != IDLE) && (r_tickCnt == TICK_MAX);
    assign w_shifting = (r_state == CMD) || (r_state == ADDR) || (r_state == DATA);
    assign w_riseTick = w_tick && w_shifting && !r_sclk;
    assign w_fallTick = w_tick && w_shifting && r_sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start && (len != '0)) w_nextState = CMD;
            CMD:     if (w_fallTick && (r_bitCnt == BW'(7)))  w_nextState = ADDR;
            ADDR:    if (w_fallTick && (r_bitCnt == BW'(31))) w_nextState = DATA;
            DATA:    if (w_fallTick && (r_bitCnt == r_lastBit)) w_nextState = FINISH;
            FINISH:  if (w_tick) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tickCnt <= '0;
            r_sclk    <= 1'b0;
            r_bitCnt  <= '0;
            r_lastBit <= '0;
            r_txSr    <= '0;
            r_rxSr    <= '0;
            r_dataOut <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (r_state == IDLE) begin
                r_tickCnt <= '0;
                r_sclk    <= 1'b0;
                r_bitCnt  <= '0;
                if (start) begin
                    r_txSr    <= {8'h03, addr};
                    r_lastBit <= BW'(31) + BW'({len, 3'b000});
                    r_done    <= (len == '0);
                end
            end else begin
                r_tickCnt <= w_tick ? '0 : r_tickCnt + CW'(1);
                if (w_riseTick) begin
                    r_sclk <= 1'b1;
                    r_rxSr <= {r_rxSr[6:0], spi_miso};
                    if ((r_state == DATA) && (r_bitCnt[2:0] == 3'd7)) begin
                        r_dataOut <= {r_rxSr[6:0], spi_miso};
                        r_valid   <= 1'b1;
                    end
                end
                if (w_fallTick) begin
                    r_sclk   <= 1'b0;
                    r_bitCnt <= r_bitCnt + BW'(1);
                    r_txSr   <= {r_txSr[30:0], 1'b0};
                end
                if ((r_state == FINISH) && w_tick) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    // Pin levels follow the state directly so an async reset idles them at once.
    always_comb begin
        busy     = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        case (r_state)
            CMD, ADDR: begin
                busy     = 1'b1;
                spi_cs_n = 1'b0;
                spi_mosi = r_txSr[31];
            end
            DATA: begin
                busy     = 1'b1;
                spi_cs_n = 1'b0;
            end
            FINISH:  busy = 1'b1;
            default: ;
        endcase
    end

    assign spi_sclk   = r_sclk;
    assign data_out   = r_dataOut;
    assign data_valid = r_valid;
    assign done       = r_done;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed self-checking bench for spi_flash_reader with a behavioural SPI flash model.
// A second instance with CLK_DIV=3 covers the slower tick rate.
module tb_spi_flash_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [23:0] addr;
    logic [7:0]  len;
    logic        busy, done, data_valid, spi_sclk, spi_cs_n, spi_mosi, spi_miso;
    logic [7:0]  data_out;

    logic        start3;
    logic [23:0] addr3 = 24'h0000AA;
    logic [7:0]  len3  = 8'd1;
    logic        busy3, done3, data_valid3, spi_sclk3, spi_cs_n3, spi_mosi3;
    logic [7:0]  data_out3;

    logic        misoModel = 1'b0;
    logic        misoToggle;
    logic        toggleEn;
    logic        prevSclk = 1'b0;
    int          rises = 0;
    logic [31:0] mosiCap = '0;
    logic [7:0]  modelBytes [8];

    int          errors = 0;
    int          checks = 0;
    int          vCyc [8];
    logic [7:0]  vByte [8];
    int          dc, cf, cl, nv, bb;
    int          sawPulse, csLow3, done3Cyc, valid3Cyc, valid3Cnt;

    always #5 clk = ~clk;

    assign spi_miso = toggleEn ? misoToggle : misoModel;

    spi_flash_reader #(.CLK_DIV(1), .LEN_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .len(len),
        .busy(busy), .done(done), .data_out(data_out), .data_valid(data_valid),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_flash_reader #(.CLK_DIV(3), .LEN_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .addr(addr3), .len(len3),
        .busy(busy3), .done(done3), .data_out(data_out3), .data_valid(data_valid3),
        .spi_sclk(spi_sclk3), .spi_cs_n(spi_cs_n3), .spi_mosi(spi_mosi3), .spi_miso(1'b1)
    );

    // Flash model: captures command/address on rising SCLK, shifts data out on falling SCLK.
    always @(spi_sclk or spi_cs_n) begin
        if (spi_cs_n) begin
            rises = 0;
            misoModel = 1'b0;
        end else if (spi_sclk && !prevSclk) begin
            if (rises < 32) mosiCap = {mosiCap[30:0], spi_mosi};
            rises = rises + 1;
        end else if (!spi_sclk && prevSclk) begin
            if ((rises >= 32) && (((rises - 32) / 8) < 8))
                misoModel = modelBytes[(rises - 32) / 8][7 - ((rises - 32) % 8)];
        end
        prevSclk = spi_sclk;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one read and watch it until done, returning at the negedge of the done cycle.
    // intr > 0 pulses a stray start with different addr/len in that cycle.
    task automatic applyStimulus(input logic [23:0] a, input logic [7:0] l, input int intr,
                                 output int doneCyc, output int csFirst, output int csLast,
                                 output int nValid, output int busyBad);
        doneCyc = -1; csFirst = -1; csLast = -1; nValid = 0; busyBad = 0;
        addr = a; len = l; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; addr = 24'h000000; len = 8'hEE;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start = (cyc == intr);
            if (cyc == intr) begin
                addr = 24'hABCDEF;
                len  = 8'd9;
            end
            if (spi_cs_n === 1'b0) begin
                if (csFirst < 0) csFirst = cyc;
                csLast = cyc;
            end
            if (data_valid === 1'b1) begin
                if (nValid < 8) begin
                    vCyc[nValid]  = cyc;
                    vByte[nValid] = data_out;
                end
                nValid++;
            end
            if (done === 1'b1) begin
                doneCyc = cyc;
                if (busy !== 1'b0) busyBad++;
                break;
            end
            if (busy !== (l != 8'd0)) busyBad++;
        end
    endtask

    initial begin
        // Reset held while the MISO pin toggles: everything must sit idle.
        rst_n = 1'b0; start = 1'b0; start3 = 1'b0; addr = '0; len = '0;
        toggleEn = 1'b1; misoToggle = 1'b0; sawPulse = 0;
        for (int i = 0; i < 8; i++) modelBytes[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            misoToggle = ~misoToggle;
            if ((done !== 1'b0) || (data_valid !== 1'b0)) sawPulse++;
        end
        checkOutput("rst_pulses", 32'(sawPulse), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_valid", 32'(data_valid), 32'd0);
        checkOutput("rst_data", 32'(data_out), 32'h00);
        checkOutput("rst_sclk", 32'(spi_sclk), 32'd0);
        checkOutput("rst_csn", 32'(spi_cs_n), 32'd1);
        checkOutput("rst_mosi", 32'(spi_mosi), 32'd0);
        checkOutput("rst_csn3", 32'(spi_cs_n3), 32'd1);
        toggleEn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte read at CLK_DIV=1.
        $display("[TB] single byte read");
        modelBytes[0] = 8'hA5;
        applyStimulus(24'h123456, 8'd1, 0, dc, cf, cl, nv, bb);
        checkOutput("t2_mosi", mosiCap, 32'h03123456);
        checkOutput("t2_nvalid", 32'(nv), 32'd1);
        checkOutput("t2_byte", 32'(vByte[0]), 32'hA5);
        checkOutput("t2_vcyc", 32'(vCyc[0]), 32'd80);
        checkOutput("t2_done", 32'(dc), 32'd82);
        checkOutput("t2_csfirst", 32'(cf), 32'd1);
        checkOutput("t2_cslast", 32'(cl), 32'd80);
        checkOutput("t2_busy", 32'(bb), 32'd0);
        @(negedge clk);
        checkOutput("t2_hold", 32'(data_out), 32'hA5);
        checkOutput("t2_donepulse", 32'(done), 32'd0);

        // Four byte burst, bytes 16 clk apart.
        $display("[TB] four byte read");
        modelBytes[0] = 8'h11; modelBytes[1] = 8'h22; modelBytes[2] = 8'h33; modelBytes[3] = 8'h44;
        applyStimulus(24'h000100, 8'd4, 0, dc, cf, cl, nv, bb);
        checkOutput("t3_nvalid", 32'(nv), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t3_byte%0d", i), 32'(vByte[i]), 32'((i + 1) * 8'h11));
            checkOutput($sformatf("t3_vcyc%0d", i), 32'(vCyc[i]), 32'(80 + 16 * i));
        end
        checkOutput("t3_done", 32'(dc), 32'd130);
        checkOutput("t3_cslast", 32'(cl), 32'd128);
        checkOutput("t3_busy", 32'(bb), 32'd0);
        @(negedge clk);
        checkOutput("t3_donepulse", 32'(done), 32'd0);
        repeat (2) @(negedge clk);

        // Zero-length read: immediate done, no bus activity.
        $display("[TB] zero length read");
        applyStimulus(24'h777777, 8'd0, 0, dc, cf, cl, nv, bb);
        checkOutput("t4_done", 32'(dc), 32'd1);
        checkOutput("t4_cs", 32'(cf), 32'hFFFFFFFF);
        checkOutput("t4_busy", 32'(bb), 32'd0);
        checkOutput("t4_nvalid", 32'(nv), 32'd0);
        repeat (2) @(negedge clk);

        // Stray start during ADDR is ignored; a start in the done cycle chains.
        $display("[TB] start while busy and back-to-back");
        modelBytes[0] = 8'hC3;
        applyStimulus(24'h654321, 8'd1, 20, dc, cf, cl, nv, bb);
        checkOutput("t5_mosi", mosiCap, 32'h03654321);
        checkOutput("t5_done", 32'(dc), 32'd82);
        checkOutput("t5_byte", 32'(vByte[0]), 32'hC3);
        modelBytes[0] = 8'h5A;
        applyStimulus(24'h00000F, 8'd1, 0, dc, cf, cl, nv, bb);
        checkOutput("t5b_csfirst", 32'(cf), 32'd1);
        checkOutput("t5b_mosi", mosiCap, 32'h0300000F);
        checkOutput("t5b_byte", 32'(vByte[0]), 32'h5A);
        checkOutput("t5b_done", 32'(dc), 32'd82);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of the address phase.
        $display("[TB] async reset mid-address");
        addr = 24'h222222; len = 8'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("t6_csn_pre", 32'(spi_cs_n), 32'd0);
        checkOutput("t6_sclk_pre", 32'(spi_sclk), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_csn", 32'(spi_cs_n), 32'd1);
        checkOutput("t6_sclk", 32'(spi_sclk), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_mosi", 32'(spi_mosi), 32'd0);
        checkOutput("t6_data", 32'(data_out), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // CLK_DIV=3 instance, MISO tied high so the byte reads back as FF.
        $display("[TB] CLK_DIV=3 read");
        csLow3 = 0; done3Cyc = -1; valid3Cyc = -1; valid3Cnt = 0;
        start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (spi_cs_n3 === 1'b0) csLow3++;
            if (data_valid3 === 1'b1) begin
                valid3Cyc = cyc;
                valid3Cnt++;
            end
            if (done3 === 1'b1) begin
                done3Cyc = cyc;
                break;
            end
        end
        checkOutput("t7_done", 32'(done3Cyc), 32'd244);
        checkOutput("t7_cslow", 32'(csLow3), 32'd240);
        checkOutput("t7_vcnt", 32'(valid3Cnt), 32'd1);
        checkOutput("t7_vcyc", 32'(valid3Cyc), 32'd238);
        checkOutput("t7_data", 32'(data_out3), 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
